nec_ir_transmitter: RTL and testbench

- NEC-protocol IR transmitter; the transmit-side counterpart of the board's IR_RECEIVE decoder.
- Serialises {~cmd, cmd, addr-high-byte, addr-low-byte} LSB-first with leader, bit and stop marks.
- Gates the envelope with an internally generated 38 kHz carrier (1/3 duty).
- Emits NEC repeat codes every frame period while hold is asserted.
- Sits between user logic (KEY/SW test pattern) and IRDA_TXD in the DE10-Standard top level.

---
 rtl/nec_ir_pkg.sv | 31 +++
 rtl/nec_ir_transmitter_carrier.sv | 20 ++
 rtl/nec_ir_transmitter.sv | 97 +++++++++
 tb/tb_nec_ir_transmitter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/nec_ir_pkg.sv
// nec_ir_pkg: shared state encoding, NEC unit counts and default timing derivations
package nec_ir_pkg;
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LEAD_MARK  = 4'd1,
    LEAD_SPACE = 4'd2,
    BIT_MARK   = 4'd3,
    BIT_SPACE  = 4'd4,
    STOP_MARK  = 4'd5,
    GAP        = 4'd6,
    REP_MARK   = 4'd7,
    REP_SPACE  = 4'd8,
    REP_STOP   = 4'd9
  } state_t;
  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int BIT_MARK_U   = 1;
  localparam int ZERO_SPACE_U = 1;
  localparam int ONE_SPACE_U  = 3;
  localparam int REP_SPACE_U  = 4;
  localparam int STOP_U       = 1;
  localparam int CLK_HZ       = 50_000_000;
  localparam int CARRIER_HZ   = 38_000;
  localparam int DEF_UNIT_CYCLES = CLK_HZ / 1_000_000 * 5625 / 10;
  localparam int DEF_CARR_PERIOD = (CLK_HZ + CARRIER_HZ / 2) / CARRIER_HZ;
  localparam int DEF_CARR_HIGH   = (DEF_CARR_PERIOD + 2) / 3;
  localparam int DEF_FRAME_UNITS = 196;
  function automatic logic is_mark(state_t s);
    return s inside {LEAD_MARK, BIT_MARK, STOP_MARK, REP_MARK, REP_STOP};
  endfunction
endpackage

// File: rtl/nec_ir_transmitter_carrier.sv
// nec_carrier_gen: wrapping carrier phase counter with synchronous restart
module nec_carrier_gen #(
  parameter int CARR_PERIOD = 1316,
  parameter int CARR_HIGH   = 439
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic carrier
);
  localparam int PW = CARR_PERIOD > 1 ? $clog2(CARR_PERIOD) : 1;
  logic [PW-1:0] phase, phase_nxt;
  assign phase_nxt = (restart || phase == PW'(CARR_PERIOD - 1)) ? '0 : phase + PW'(1);
  // carrier for the coming cycle, so the caller can register it together with the envelope
  assign carrier = phase_nxt < PW'(CARR_HIGH);
  always_ff @(posedge clk) begin
    if (!rst_n) phase <= '0;
    else phase <= phase_nxt;
  end
endmodule

// File: rtl/nec_ir_transmitter.sv
// nec_ir_transmitter: NEC frame and repeat-code serialiser gated by a 38 kHz carrier
module nec_ir_transmitter
  import nec_ir_pkg::*;
#(
  parameter int UNIT_CYCLES = DEF_UNIT_CYCLES,
  parameter int CARR_PERIOD = DEF_CARR_PERIOD,
  parameter int CARR_HIGH   = DEF_CARR_HIGH,
  parameter int FRAME_UNITS = DEF_FRAME_UNITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send,
  input  logic [15:0] addr,
  input  logic        ext_addr,
  input  logic [7:0]  cmd,
  input  logic        hold,
  output logic        busy,
  output logic        done,
  output logic        env,
  output logic        ir_out,
  output logic [3:0]  tx_state
);
  localparam int UW = UNIT_CYCLES > 1 ? $clog2(UNIT_CYCLES) : 1;
  localparam int FW = $clog2(FRAME_UNITS + 1);
  localparam logic [UW-1:0] U_LAST = UW'(UNIT_CYCLES - 1);
  localparam logic [FW-1:0] F_END  = FW'(FRAME_UNITS);
  localparam logic [FW-1:0] F_LAST = FW'(FRAME_UNITS - 1);
  state_t state, state_nxt;
  logic [31:0] word;
  logic [UW-1:0] unit_cnt, unit_cnt_nxt;
  logic [4:0] st_units, st_units_nxt, need, bit_idx;
  logic [FW-1:0] frame_cnt;
  logic unit_tick, last, gap_end, env_nxt, restart, carrier, done_nxt;
  assign tx_state = state;
  assign unit_tick = unit_cnt == U_LAST;
  assign need = (state == LEAD_MARK || state == REP_MARK) ? 5'(LEAD_MARK_U)
              : state == LEAD_SPACE ? 5'(LEAD_SPACE_U)
              : state == BIT_MARK ? 5'(BIT_MARK_U)
              : state == BIT_SPACE ? (word[bit_idx] ? 5'(ONE_SPACE_U) : 5'(ZERO_SPACE_U))
              : state == REP_SPACE ? 5'(REP_SPACE_U) : 5'(STOP_U);
  assign last = unit_tick && st_units == need - 5'd1;
  // a frame that already overran the spacing still spends one cycle in GAP
  assign gap_end = frame_cnt == F_END || (unit_tick && frame_cnt == F_LAST);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = send ? LEAD_MARK : IDLE;
      LEAD_MARK:  state_nxt = last ? LEAD_SPACE : state;
      LEAD_SPACE: state_nxt = last ? BIT_MARK : state;
      BIT_MARK:   state_nxt = last ? BIT_SPACE : state;
      BIT_SPACE:  state_nxt = !last ? state : bit_idx == 5'd31 ? STOP_MARK : BIT_MARK;
      STOP_MARK:  state_nxt = last ? GAP : state;
      GAP:        state_nxt = !gap_end ? state : hold ? REP_MARK : IDLE;
      REP_MARK:   state_nxt = last ? REP_SPACE : state;
      REP_SPACE:  state_nxt = last ? REP_STOP : state;
      REP_STOP:   state_nxt = last ? GAP : state;
      default:    state_nxt = IDLE;
    endcase
    unit_cnt_nxt = (state_nxt != state || unit_tick) ? '0 : unit_cnt + UW'(1);
    st_units_nxt = state_nxt != state ? '0 : st_units + 5'(unit_tick);
  end
  assign env_nxt = is_mark(state_nxt);
  assign restart = env_nxt && !env;
  assign done_nxt = (state_nxt == STOP_MARK || state_nxt == REP_STOP) &&
                    unit_cnt_nxt == U_LAST && st_units_nxt == 5'(STOP_U - 1);
  nec_carrier_gen #(.CARR_PERIOD(CARR_PERIOD), .CARR_HIGH(CARR_HIGH)) u_carrier (
    .clk(clk), .rst_n(rst_n), .restart(restart), .carrier(carrier)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      unit_cnt <= '0;
      st_units <= '0;
      bit_idx <= '0;
      frame_cnt <= '0;
      word <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      env <= 1'b0;
      ir_out <= 1'b0;
    end else begin
      state <= state_nxt;
      unit_cnt <= unit_cnt_nxt;
      st_units <= st_units_nxt;
      busy <= state_nxt != IDLE;
      done <= done_nxt;
      env <= env_nxt;
      ir_out <= env_nxt && carrier;
      if (state == IDLE && send) begin
        word <= {~cmd, cmd, ext_addr ? addr[15:8] : ~addr[7:0], addr[7:0]};
        bit_idx <= '0;
      end else if (state == BIT_SPACE && last) bit_idx <= bit_idx + 5'd1;
      if (state_nxt != state && (state_nxt == LEAD_MARK || state_nxt == REP_MARK)) frame_cnt <= '0;
      else if (unit_tick && frame_cnt != F_END) frame_cnt <= frame_cnt + FW'(1);
    end
  end
endmodule

// File: tb/tb_nec_ir_transmitter.sv
// tb_nec_ir_transmitter: randomized frames and repeats checked against a unit-level NEC waveform model
module tb_nec_ir_transmitter;
  localparam int U = 4, CP = 3, CH = 1, FU = 196, FL = FU * U;
  logic clk = 0, rst_n = 0, send = 0, ext_addr = 0, hold = 0;
  logic [15:0] addr = 0;
  logic [7:0] cmd = 0;
  logic busy, done, env, ir_out;
  logic [3:0] tx_state;
  int total = 0, bad = 0;
  bit e_env[$], e_ir[$], e_done[$];
  int e_st[$];

  always #5 clk = ~clk;

  nec_ir_transmitter #(.UNIT_CYCLES(U), .CARR_PERIOD(CP), .CARR_HIGH(CH), .FRAME_UNITS(FU)) dut (
    .clk(clk), .rst_n(rst_n), .send(send), .addr(addr), .ext_addr(ext_addr), .cmd(cmd),
    .hold(hold), .busy(busy), .done(done), .env(env), .ir_out(ir_out), .tx_state(tx_state)
  );

  function automatic logic [31:0] nec_word(logic [15:0] a, logic e, logic [7:0] c);
    return {~c, c, e ? a[15:8] : ~a[7:0], a[7:0]};
  endfunction

  task automatic add_seg(bit lvl, int units, int st);
    for (int k = 0; k < units * U; k++) begin
      e_env.push_back(lvl);
      e_ir.push_back(lvl && (k % CP) < CH);
      e_done.push_back((st == 5 || st == 9) && k == units * U - 1);
      e_st.push_back(st);
    end
  endtask

  task automatic pad_gap(int upto);
    while (e_env.size() < upto) begin
      e_env.push_back(0);
      e_ir.push_back(0);
      e_done.push_back(0);
      e_st.push_back(6);
    end
  endtask

  task automatic build_model(logic [31:0] w, int nrep);
    e_env.delete(); e_ir.delete(); e_done.delete(); e_st.delete();
    add_seg(1, 16, 1);
    add_seg(0, 8, 2);
    for (int b = 0; b < 32; b++) begin
      add_seg(1, 1, 3);
      add_seg(0, w[b] ? 3 : 1, 4);
    end
    add_seg(1, 1, 5);
    pad_gap(FL);
    for (int r = 1; r <= nrep; r++) begin
      add_seg(1, 16, 7);
      add_seg(0, 4, 8);
      add_seg(1, 1, 9);
      pad_gap(FL * (r + 1));
    end
    e_env.push_back(0); e_ir.push_back(0); e_done.push_back(0); e_st.push_back(0);
  endtask

  task automatic start_frame(logic [15:0] a, logic e, logic [7:0] c);
    @(negedge clk);
    addr = a; ext_addr = e; cmd = c; send = 1;
    @(negedge clk);
    send = 0;
  endtask

  // entered at the negedge of the first LEAD_MARK cycle; leaves at the negedge of the first IDLE cycle
  task automatic check_seq(input logic [31:0] w, input int nrep, input bit poke, input bit end_send,
                           input logic [15:0] na, input logic ne, input logic [7:0] nc);
    int len, n_env = 0, n_ir = 0, n_done = 0, n_busy = 0, n_st = 0, dones = 0, drop = -1, first = -1;
    int cur = 1, lead_m = -1, lead_s = -1;
    int runs[$];
    bit got[$];
    logic [31:0] dec = 0;
    build_model(w, nrep);
    len = e_env.size() - 1;
    hold = nrep > 0;
    for (int i = 0; i <= len; i++) begin
      if (env !== e_env[i]) begin n_env++; if (first < 0) first = i; end
      if (ir_out !== e_ir[i]) n_ir++;
      if (done !== e_done[i]) n_done++;
      if (busy !== (i < len)) n_busy++;
      if (tx_state !== 4'(e_st[i])) n_st++;
      if (done === 1'b1) dones++;
      if (busy === 1'b0 && drop < 0) drop = i;
      got.push_back(env === 1'b1);
      if (i < len) begin
        if (i < len - 1) begin addr = 16'($urandom); ext_addr = 1'($urandom); cmd = 8'($urandom); end
        send = poke && i == 5;
        if (nrep > 0 && i == FL * nrep) hold = 0;
        if (end_send && i == len - 1) begin addr = na; ext_addr = ne; cmd = nc; send = 1; end
        @(negedge clk);
      end
    end
    for (int i = 1; i < FL; i++)
      if (got[i] == got[i-1]) cur++;
      else begin runs.push_back(cur); cur = 1; end
    if (runs.size() >= 2) begin lead_m = runs[0]; lead_s = runs[1]; end
    for (int b = 0; b < 32; b++)
      if (3 + 2 * b < runs.size()) dec[b] = runs[3 + 2 * b] > 2 * U;
    total++; if (n_env !== 0) begin bad++; $display("FAIL env_wave: %0d cycles wrong (first at %0d), want 0", n_env, first); end
    total++; if (n_ir !== 0) begin bad++; $display("FAIL ir_out_wave: %0d cycles wrong, want 0", n_ir); end
    total++; if (n_done !== 0) begin bad++; $display("FAIL done_wave: %0d cycles wrong, want 0", n_done); end
    total++; if (n_busy !== 0) begin bad++; $display("FAIL busy_wave: %0d cycles wrong, want 0", n_busy); end
    total++; if (n_st !== 0) begin bad++; $display("FAIL tx_state_wave: %0d cycles wrong, want 0", n_st); end
    total++; if (dec !== w) begin bad++; $display("FAIL decoded_word: got %h want %h", dec, w); end
    total++; if (lead_m !== 16 * U) begin bad++; $display("FAIL lead_mark_len: got %0d want %0d", lead_m, 16 * U); end
    total++; if (lead_s !== 8 * U) begin bad++; $display("FAIL lead_space_len: got %0d want %0d", lead_s, 8 * U); end
    total++; if (dones !== nrep + 1) begin bad++; $display("FAIL done_count: got %0d want %0d", dones, nrep + 1); end
    total++; if (drop !== FL * (nrep + 1)) begin bad++; $display("FAIL busy_drop_cycle: got %0d want %0d", drop, FL * (nrep + 1)); end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (env !== 1'b0) begin bad++; $display("FAIL reset_env: got %b want 0", env); end
    total++; if (ir_out !== 1'b0) begin bad++; $display("FAIL reset_ir_out: got %b want 0", ir_out); end
    total++; if (tx_state !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", tx_state); end
    rst_n = 1;
  endtask

  task automatic test_hold_idle;
    int n = 0;
    hold = 1;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_state !== 4'd0 || env !== 1'b0) n++;
    end
    hold = 0;
    total++; if (n !== 0) begin bad++; $display("FAIL hold_idle: %0d active cycles want 0", n); end
  endtask

  task automatic test_directed_frame;
    start_frame(16'h0086, 1'b0, 8'h12);
    check_seq(32'hED127986, 0, 0, 0, 16'h0, 1'b0, 8'h0);
  endtask

  task automatic test_random_frames;
    logic [15:0] a; logic e; logic [7:0] c;
    repeat (3) begin
      a = 16'($urandom); e = 1'($urandom); c = 8'($urandom);
      start_frame(a, e, c);
      check_seq(nec_word(a, e, c), int'($urandom_range(0, 1)), 0, 0, 16'h0, 1'b0, 8'h0);
    end
  endtask

  task automatic test_repeat;
    start_frame(16'h6B86, 1'b1, 8'h12);
    check_seq(32'hED126B86, 3, 0, 0, 16'h0, 1'b0, 8'h0);
  endtask

  task automatic test_back_to_back;
    logic [15:0] a = 16'($urandom), b = 16'($urandom);
    logic [7:0] c = 8'($urandom), d = 8'($urandom);
    start_frame(a, 1'b1, c);
    check_seq(nec_word(a, 1'b1, c), 0, 1, 1, b, 1'b0, d);
    @(negedge clk);
    send = 0;
    check_seq(nec_word(b, 1'b0, d), 0, 0, 0, 16'h0, 1'b0, 8'h0);
  endtask

  task automatic test_reset_mid;
    int cnt = 0, guard = 0;
    logic [15:0] a = 16'($urandom);
    logic [7:0] c = 8'($urandom);
    start_frame(16'hFFFF, 1'b1, 8'h5A);
    while (cnt < 10 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (tx_state === 4'd4) cnt++;
    end
    total++; if (cnt !== 10) begin bad++; $display("FAIL bit_space_wait: saw %0d cycles want 10", cnt); end
    rst_n = 0;
    @(negedge clk);
    total++; if (env !== 1'b0) begin bad++; $display("FAIL midreset_env: got %b want 0", env); end
    total++; if (ir_out !== 1'b0) begin bad++; $display("FAIL midreset_ir_out: got %b want 0", ir_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
    total++; if (tx_state !== 4'd0) begin bad++; $display("FAIL midreset_state: got %0d want 0", tx_state); end
    rst_n = 1;
    start_frame(a, 1'b0, c);
    check_seq(nec_word(a, 1'b0, c), 0, 0, 0, 16'h0, 1'b0, 8'h0);
  endtask

  initial begin
    test_reset;
    test_hold_idle;
    test_directed_frame;
    test_random_frames;
    test_repeat;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
